// File: rtl/serial_link_arbiter.sv
// rtl/serial_link_arbiter.sv - round-robin arbiter sequencing one shared 16-bit serial link; LINK_CHECK_EN enables loopback compare
module serial_link_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_err,
  input  logic                       rsp_ready,
  output logic                       link_load_shift,
  output logic [WIDTH-1:0]           link_pin,
  input  logic [WIDTH-1:0]           link_pout,
  input  logic                       link_complete,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [TW-1:0]    timer;
  logic             timeout_hit;
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] req_words [NUM_REQ];
  logic             check_err;

  // Unpack the flat request bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_words[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = (int'(rr_ptr) + k) % NUM_REQ;
      cand = IDW'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign timeout_hit = (timer == TW'(TIMEOUT - 1));

  // Loopback compare of the captured word against what was sent.
`ifdef LINK_CHECK_EN
  assign check_err = (link_pout != word_q);
`else
  assign check_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_n         = state;
    req_ready       = '0;
    link_load_shift = 1'b0;
    rsp_valid       = 1'b0;
    busy            = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (win_found && link_complete) begin
          state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        req_ready[id_q] = 1'b1;
        state_n         = S_LOAD;
      end
      S_LOAD: begin
        link_load_shift = 1'b1;
        state_n         = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!link_complete) begin
          state_n = S_WAIT_DONE;
        end else if (timeout_hit) begin
          state_n = S_RESP;
        end
      end
      S_WAIT_DONE: begin
        if (link_complete || timeout_hit) begin
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath: winner latch, rotation pointer, phase timer and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      id_q       <= '0;
      word_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found && link_complete) begin
            id_q       <= win_id;
            word_q     <= req_words[win_id];
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
          end
        end
        S_GRANT: begin
          rr_ptr <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
        S_LOAD: begin
          timer <= '0;
        end
        S_WAIT_START: begin
          if (!link_complete) begin
            timer <= '0;
          end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (link_complete) begin
            rsp_data_q <= link_pout;
            rsp_err_q  <= check_err;
          end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            word_q <= '0;
            timer  <= '0;
          end
        end
        default: begin
          timer <= '0;
        end
      endcase
    end
  end

  assign link_pin = word_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// tb/tb_serial_link_arbiter.sv - scoreboard bench for serial_link_arbiter with an ideal link model
module tb_serial_link_arbiter;

  localparam int NR  = 4;
  localparam int W   = 16;
  localparam int TO  = 64;
  localparam int IDW = 2;
`ifdef LINK_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic           err;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_err;
  logic              rsp_ready;
  logic              link_load_shift;
  logic [W-1:0]      link_pin;
  logic [W-1:0]      link_pout;
  logic              link_complete;
  logic              busy;

  int          total = 0;
  int          bad = 0;
  int          grant_seen = 0;
  int          exp_grant[$];
  logic [W-1:0] exp_pin[$];
  rsp_t        exp_rsp[$];

  int          link_s = 16;
  bit          link_stuck = 1'b0;
  logic [W-1:0] link_mask = '0;

  serial_link_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .link_load_shift(link_load_shift),
    .link_pin(link_pin),
    .link_pout(link_pout),
    .link_complete(link_complete),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [W-1:0] pin, input logic [W-1:0] data, input logic err);
    rsp_t r;
    exp_grant.push_back(id);
    exp_pin.push_back(pin);
    r.id   = IDW'(id);
    r.data = data;
    r.err  = err;
    exp_rsp.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input int i);
    int n = 0;
    while (req_ready[i] !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check("grant_wait", 32'(n < 300), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_grant.size() != 0 || exp_pin.size() != 0 || busy) && n < 400) begin
      step();
      n++;
    end
    check(tag, 32'(n < 400), 32'd1);
  endtask

  // Ideal link: complete drops one cycle after the load pulse, rises link_s cycles later.
  initial begin
    link_complete = 1'b1;
    link_pout     = '0;
    forever begin
      @(negedge clk);
      if (link_load_shift && !link_stuck) begin
        @(negedge clk);
        link_complete = 1'b0;
        repeat (link_s) @(negedge clk);
        link_pout     = link_pin ^ link_mask;
        link_complete = 1'b1;
      end
    end
  end

  // Scoreboard monitor: grants, load pulses and response handshakes.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (req_ready != '0) begin
        grant_seen++;
        check("grant_expected", 32'(exp_grant.size() > 0), 32'd1);
        if (exp_grant.size() > 0) begin
          logic [NR-1:0] oh;
          oh = '0;
          oh[exp_grant.pop_front()] = 1'b1;
          check("grant_onehot", 32'(req_ready), 32'(oh));
        end
      end
      if (link_load_shift) begin
        check("pin_expected", 32'(exp_pin.size() > 0), 32'd1);
        if (exp_pin.size() > 0) begin
          check("link_pin", 32'(link_pin), 32'(exp_pin.pop_front()));
        end
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
        if (exp_rsp.size() > 0) begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(r.id));
          check("rsp_data", 32'(rsp_data), 32'(r.data));
          check("rsp_err", 32'(rsp_err), 32'(r.err));
        end
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_load", 32'(link_load_shift), 32'd0);
    check("rst_link_pin", 32'(link_pin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step();

    // Round-robin with all requesters continuously valid.
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    push(0, 16'h1111, 16'h1111, 1'b0);
    push(1, 16'h2222, 16'h2222, 1'b0);
    push(2, 16'h3333, 16'h3333, 1'b0);
    push(3, 16'h4444, 16'h4444, 1'b0);
    push(0, 16'h1111, 16'h1111, 1'b0);
    req_valid = 4'hF;
    n = 0;
    while (grant_seen < 5 && n < 1000) begin
      step();
      n++;
    end
    check("rr_grants", 32'(grant_seen), 32'd5);
    req_valid = '0;
    drain("rr_drain");

    // Single request from requester 2 with latency measurement.
    req_data = '0;
    req_data[2*W +: W] = 16'hA5C3;
    push(2, 16'hA5C3, 16'hA5C3, 1'b0);
    req_valid[2] = 1'b1;
    wait_grant(2);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("single_latency", 32'(n), 32'(link_s + 3));
    drain("single_drain");

    // Backpressure: requester 0 answered while 2 waits.
    rsp_ready = 1'b0;
    req_data[0*W +: W] = 16'h0A0A;
    req_data[2*W +: W] = 16'h2B2B;
    push(0, 16'h0A0A, 16'h0A0A, 1'b0);
    push(2, 16'h2B2B, 16'h2B2B, 1'b0);
    req_valid = 4'b0101;
    wait_grant(0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h0A0A);
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_no_grant", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    wait_grant(2);
    drain("bp_drain");

    // Timeout with complete stuck high.
    link_stuck = 1'b1;
    req_data[1*W +: W] = 16'h5A5A;
    push(1, 16'h5A5A, 16'h0000, 1'b1);
    req_valid[1] = 1'b1;
    wait_grant(1);
    step();
    check("to_load", 32'(link_load_shift), 32'd1);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("to_cycles", 32'(n), 32'(TO + 1));
    drain("to_drain");
    link_stuck = 1'b0;

    // Link corrupts bit 0: error flagged only with loopback compare enabled.
    link_mask = 16'h0001;
    req_data[0*W +: W] = 16'hA5C3;
    push(0, 16'hA5C3, 16'hA5C2, CHECK_EN);
    req_valid[0] = 1'b1;
    wait_grant(0);
    drain("chk_drain");
    link_mask = '0;

    // Reset during WAIT_DONE drops the word; rotation restarts at 0.
    req_data[1*W +: W] = 16'hBEEF;
    exp_grant.push_back(1);
    exp_pin.push_back(16'hBEEF);
    req_valid[1] = 1'b1;
    wait_grant(1);
    repeat (7) step();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_load", 32'(link_load_shift), 32'd0);
    check("mid_rst_pin", 32'(link_pin), 32'd0);
    step();
    rst = 1'b1;
    req_data[0*W +: W] = 16'h0F0F;
    req_data[3*W +: W] = 16'h3C3C;
    push(0, 16'h0F0F, 16'h0F0F, 1'b0);
    push(3, 16'h3C3C, 16'h3C3C, 1'b0);
    req_valid = 4'b1001;
    wait_grant(0);
    wait_grant(3);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_link_arbiter.md
Name: serial_link_arbiter

Overview:
- Shares one 16-bit PISO-to-SIPO serial link between NUM_REQ requesters.
- Round-robin arbitrates word requests.
- Sequences the link for each granted word: one-cycle load_shift pulse, then waits for complete.
- Captures the parallel output word and returns it to the winning requester tagged with its id; it sits directly in front of the serial link datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, word width; must match the link.
- TIMEOUT, 64, cycles allowed per link phase before the transfer is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot accept; asserted for one cycle in GRANT.
- rsp_valid  out  1  response word valid.
- rsp_data  out  WIDTH  word captured from the link.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_err  out  1  response is an error (timeout, or mismatch when the feature is enabled).
- rsp_ready  in  1  response consumer accept.
- link_load_shift  out  1  load pulse to the link.
- link_pin  out  WIDTH  parallel word to the link.
- link_pout  in  WIDTH  parallel word from the link.
- link_complete  in  1  link idle / transfer done (level).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, timer=0. All outputs 0: req_ready, rsp_*, link_load_shift, link_pin, busy.
- FSM states: IDLE, GRANT, LOAD, WAIT_START, WAIT_DONE, RESP.
- IDLE:
  - Requires any req_valid=1 and link_complete=1 to move on.
  - Winner is the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Latch winner id and its word; go to GRANT.
- GRANT: req_ready[id]=1 for exactly one cycle; rr_ptr <= (id+1) mod NUM_REQ; go to LOAD.
- LOAD:
  - link_load_shift=1 for exactly one cycle; link_pin holds the latched word.
  - link_pin keeps the latched word until IDLE is re-entered.
  - Go to WAIT_START; timer cleared.
- WAIT_START: wait for link_complete=0 (link started shifting); then go to WAIT_DONE with timer cleared.
- WAIT_DONE: wait for link_complete=1; then capture link_pout into rsp_data and go to RESP.
- Timeout: timer increments every cycle in WAIT_START and WAIT_DONE. On reaching TIMEOUT-1 without the awaited edge:
  - go to RESP with rsp_err=1 and rsp_data=0;
  - rr_ptr is not rolled back.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err held stable until rsp_ready=1.
  - On the cycle rsp_valid=1 and rsp_ready=1, go to IDLE; rsp_valid drops the next cycle.
- Latency with an ideal link (complete drops one cycle after the load pulse, rises S cycles later): rsp_valid asserts S+4 cycles after the IDLE decision.
- Requesters:
  - Must hold req_valid and req_data stable until req_ready.
  - A requester dropping req_valid while not granted is legal.
  - A non-granted requester is never accepted.
- Only one transfer is in flight at a time. New requests arriving in non-IDLE states wait; there is no queueing.
- Simultaneous requests from all requesters are served in rotation: each requester is granted at most once per NUM_REQ grants while all stay valid.
- rst asserted mid-transfer: immediate return to IDLE with all outputs 0; the in-flight word is dropped and no response is issued.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: LINK_CHECK_EN.
- Defined: in WAIT_DONE, captured link_pout is compared with link_pin. A mismatch sets rsp_err=1 while rsp_data still carries the captured word. This is used when the link is wired as a loopback.
- Undefined: no comparison is made; rsp_err is set only by timeout.

Test Plan:
- Single request: req_valid[2]=1, data 16'hA5C3, ideal link echoing after 16 cycles -> one-cycle req_ready[2], one-cycle link_load_shift with link_pin=16'hA5C3, then rsp_valid, rsp_id=2, rsp_data=16'hA5C3, rsp_err=0.
- Round-robin: all four requesters valid continuously, words 16'h1111..16'h4444 -> grant order 0,1,2,3,0; each response rsp_id matches its grant.
- Backpressure: rsp_ready held 0 for 10 cycles during RESP -> rsp_valid, rsp_data and rsp_id stable for all 10 cycles; no new req_ready until the handshake completes.
- Timeout: link_complete stuck at 1 after the load pulse, TIMEOUT=64 -> RESP reached 64 cycles after entering WAIT_START, with rsp_err=1 and rsp_data=16'h0000.
- Reset mid-transfer: rst=0 during WAIT_DONE -> busy, rsp_valid and link_load_shift go to 0 immediately; after release, the next request gets a fresh grant with rr_ptr=0.
- LINK_CHECK_EN defined, link returns 16'hA5C2 for pin 16'hA5C3 -> rsp_err=1, rsp_data=16'hA5C2.
